// File: rtl/dff_write_arbiter_pkg.sv
// Shared definitions for the dff_write_arbiter block: command encodings,
// arbiter FSM state encodings and a helper for index widths.
package dff_arb_pkg;

  // Command issued by a requester against the shared register.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_HOLD  = 2'b11
  } op_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_dff_reg.sv
// dff_reg: WIDTH-bit D register with synchronous reset, set, clear and load
// enable. qbar is a pure complement of q so the two can never disagree.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_reg;

  // Register update: reset dominates, then set, clear and finally load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (set) begin
      q_reg <= '1;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: shares one dff_reg among N requesters. A winner is picked
// in IDLE, its command is applied in WRITE and acknowledged in ACK.
// Build option: define DFF_ARB_FIXED_PRIO_EN for lowest-index-wins selection
// instead of round-robin (default).
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [2*N-1:0]     op,
  input  logic [WIDTH*N-1:0] d,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar,
  output logic               busy
);

  localparam int IDX_W = idx_width(N);

  op_t              op_arr [N];
  logic [WIDTH-1:0] d_arr  [N];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] winner_reg;
  op_t              op_reg;
  logic [WIDTH-1:0] d_reg;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_valid;
  logic             reg_en, reg_set, reg_clr;

`ifndef DFF_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_reg;
`endif

  // Split the flat command/data buses into per-requester slices.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign op_arr[gi] = op_t'(op[2*gi +: 2]);
      assign d_arr[gi]  = d[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Winner selection: scan candidates in reverse priority order so the
  // highest-priority asserted request is the last one written.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef DFF_ARB_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((int'(ptr_reg) + k) % N);
`endif
      if (req[cand]) begin
        sel_idx   = cand;
        sel_valid = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture winner, command and data at the selection edge; later input
  // changes cannot disturb the transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_reg <= '0;
      op_reg     <= OP_HOLD;
      d_reg      <= '0;
    end else if (state_reg == ST_IDLE && sel_valid) begin
      winner_reg <= sel_idx;
      op_reg     <= op_arr[sel_idx];
      d_reg      <= d_arr[sel_idx];
    end
  end

`ifndef DFF_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the requester being acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (state_reg == ST_ACK) begin
      ptr_reg <= (winner_reg == IDX_W'(N - 1)) ? '0 : winner_reg + IDX_W'(1);
    end
  end
`endif

  // Next-state and output decode; grant/ack are derived from the state so a
  // reset clears them on the same edge as the FSM.
  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    ack        = '0;
    busy       = 1'b0;
    reg_en     = 1'b0;
    reg_set    = 1'b0;
    reg_clr    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        gnt[winner_reg] = 1'b1;
        busy            = 1'b1;
        reg_en          = (op_reg == OP_LOAD);
        reg_set         = (op_reg == OP_SET);
        reg_clr         = (op_reg == OP_CLEAR);
        state_next      = ST_ACK;
      end
      ST_ACK: begin
        gnt[winner_reg] = 1'b1;
        ack[winner_reg] = 1'b1;
        busy            = 1'b1;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  dff_reg #(.WIDTH(WIDTH)) u_dff_reg (
    .clk   (clk),
    .reset (reset),
    .en    (reg_en),
    .set   (reg_set),
    .clr   (reg_clr),
    .d     (d_reg),
    .q     (q),
    .qbar  (qbar)
  );

endmodule
